enm_bullet_pool: RTL and testbench

ENM_BULLET_POOL -- requirements
Module: enm_bullet_pool

---
 rtl/enm_bullet_pool.sv | 208 ++++++++++++++++++++
 tb/tb_enm_bullet_pool.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enm_bullet_pool.sv
// Enemy bullet pool: every enemy owns one bullet slot per firing direction.
// Per-enemy fire timers launch idle slots, and flying slots advance each cycle.
// Slots retire when they leave the playfield, hit the player, or lose their owner.
// Hits on the player raise a one-cycle shot pulse, then a fixed invulnerability window.
//
// Handshake: there is none. All inputs are level-sampled on every clk22 edge
// while en=1, and all outputs come straight from registers.
module enm_bullet_pool #(
  parameter int N_ENM       = 4,   // enemies, 1..8
  parameter int N_DIR       = 3,   // bullets per enemy, 1..3
  parameter int FIRE_PERIOD = 16,  // cycles between fire ticks, 2..255
  parameter int SV          = 10,  // vertical bullet step
  parameter int SD          = 7,   // diagonal bullet step per axis
  parameter int XMIN        = 8,
  parameter int XMAX        = 432,
  parameter int YMAX        = 472,
  parameter int HXL         = 10,  // player hitbox half-extent, left
  parameter int HXR         = 12,  // player hitbox half-extent, right
  parameter int HY          = 11,  // player hitbox half-extent, vertical
  parameter int INVUL       = 32   // invulnerability length after a hit, >= 1
) (
  input  logic                         clk22,
  input  logic                         rst,
  input  logic                         en,
  input  logic [9:0]                   reimux,
  input  logic [9:0]                   reimuy,
  input  logic [N_ENM*10-1:0]          enm_x,
  input  logic [N_ENM*10-1:0]          enm_y,
  input  logic [N_ENM-1:0]             enm_alive,
  output logic [N_ENM*N_DIR*10-1:0]    blt_x,
  output logic [N_ENM*N_DIR*10-1:0]    blt_y,
  output logic [N_ENM*N_DIR-1:0]       blt_act,
  output logic                         shot,
  output logic                         invul
);

  localparam int NS = N_ENM * N_DIR;
  localparam int IW = (INVUL < 1) ? 1 : $clog2(INVUL + 1);
  localparam logic [7:0] RELOAD = 8'(FIRE_PERIOD - 1);

  // blt_act is the exported view of each slot's state register.
  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_t;

  // ---------------------------------------------------------------------------
  // Per-enemy fire timers
  // ---------------------------------------------------------------------------
  logic [7:0]       fcnt_q [N_ENM];
  logic [7:0]       fcnt_d [N_ENM];
  logic [N_ENM-1:0] fire_tick;

  // Count down while alive, tick and reload on zero, park at reload while dead.
  always_comb begin
    for (int e = 0; e < N_ENM; e++) begin
      fcnt_d[e]    = fcnt_q[e];
      fire_tick[e] = 1'b0;
      if (en) begin
        if (!enm_alive[e]) begin
          fcnt_d[e] = RELOAD;
        end else if (fcnt_q[e] == 8'd0) begin
          fire_tick[e] = 1'b1;
          fcnt_d[e]    = RELOAD;
        end else begin
          fcnt_d[e] = fcnt_q[e] - 8'd1;
        end
      end
    end
  end

  // Fire timer registers.
  always_ff @(posedge clk22) begin
    for (int e = 0; e < N_ENM; e++) begin
      if (rst) fcnt_q[e] <= RELOAD;
      else     fcnt_q[e] <= fcnt_d[e];
    end
  end

  // ---------------------------------------------------------------------------
  // Player hitbox bounds, 11-bit, with the lower edges clamped at 0
  // ---------------------------------------------------------------------------
  logic [10:0] px, py, hx_lo, hx_hi, hy_lo, hy_hi;
  assign px    = {1'b0, reimux};
  assign py    = {1'b0, reimuy};
  assign hx_lo = (px >= 11'(HXL)) ? (px - 11'(HXL)) : 11'd0;
  assign hx_hi = px + 11'(HXR);
  assign hy_lo = (py >= 11'(HY)) ? (py - 11'(HY)) : 11'd0;
  assign hy_hi = py + 11'(HY);

  logic [NS-1:0] hit_vec;

  // ---------------------------------------------------------------------------
  // Bullet slots: slot s = d*N_ENM + e
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < NS; s++) begin : g_slot
    localparam int D = s / N_ENM;
    localparam int E = s % N_ENM;

    slot_state_t state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [10:0] nx, ny;
    logic        in_box, oob;

    // Candidate next position; an x underflow wraps far above XMAX.
    always_comb begin
      nx = {1'b0, x_q};
      ny = {1'b0, y_q};
      if (D == 0) begin
        ny = ny + 11'(SV);
      end else if (D == 1) begin
        nx = nx - 11'(SD);
        ny = ny + 11'(SD);
      end else begin
        nx = nx + 11'(SD);
        ny = ny + 11'(SD);
      end
    end

    assign oob    = (nx < 11'(XMIN)) || (nx > 11'(XMAX)) || (ny > 11'(YMAX));
    assign in_box = (hx_lo < {1'b0, x_q}) && ({1'b0, x_q} < hx_hi) &&
                    (hy_lo < {1'b0, y_q}) && ({1'b0, y_q} < hy_hi);
    // A dead owner outranks a hit, so such a slot never damages the player.
    assign hit_vec[s] = (state_q == FLY) && in_box && enm_alive[E];

    // Slot next state: owner dead > hit > out-of-bounds > move; idle slots launch on tick.
    always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      if (en) begin
        if (!enm_alive[E]) begin
          state_d = IDLE;
          x_d     = 10'd0;
          y_d     = 10'd0;
        end else if (state_q == IDLE) begin
          if (fire_tick[E]) begin
            state_d = FLY;
            x_d     = enm_x[E*10 +: 10];
            y_d     = enm_y[E*10 +: 10];
          end
        end else if (in_box || oob) begin
          state_d = IDLE;
          x_d     = 10'd0;
          y_d     = 10'd0;
        end else begin
          x_d = nx[9:0];
          y_d = ny[9:0];
        end
      end
    end

    // Slot state and position registers.
    always_ff @(posedge clk22) begin
      if (rst) begin
        state_q <= IDLE;
        x_q     <= 10'd0;
        y_q     <= 10'd0;
      end else begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
      end
    end

    assign blt_x[s*10 +: 10] = x_q;
    assign blt_y[s*10 +: 10] = y_q;
    assign blt_act[s]        = (state_q == FLY);
  end

  // ---------------------------------------------------------------------------
  // Player damage and invulnerability
  // ---------------------------------------------------------------------------
  logic          hit_any;
  logic [IW-1:0] icnt_q, icnt_d;
  logic          shot_q, shot_d, invul_q, invul_d;

  assign hit_any = |hit_vec;

  // A hit only counts while the window is closed; counted hits reopen it.
  always_comb begin
    icnt_d = icnt_q;
    shot_d = 1'b0;
    if (en) begin
      if (hit_any && (icnt_q == '0)) begin
        shot_d = 1'b1;
        icnt_d = IW'(INVUL);
      end else if (icnt_q != '0) begin
        icnt_d = icnt_q - IW'(1);
      end
    end
    invul_d = (icnt_d != '0);
  end

  // Damage/invulnerability registers.
  always_ff @(posedge clk22) begin
    if (rst) begin
      icnt_q  <= '0;
      shot_q  <= 1'b0;
      invul_q <= 1'b0;
    end else begin
      icnt_q  <= icnt_d;
      shot_q  <= shot_d;
      invul_q <= invul_d;
    end
  end

  assign shot  = shot_q;
  assign invul = invul_q;

endmodule

// File: tb/tb_enm_bullet_pool.sv
// Directed bench for enm_bullet_pool with default parameters.
// The bench drives inputs and samples outputs 1 time unit after each rising edge.
module tb_enm_bullet_pool;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk22 = 1'b0;
  logic         rst;
  logic         en;
  logic [9:0]   reimux, reimuy;
  logic [39:0]  enm_x, enm_y;
  logic [3:0]   enm_alive;
  logic [119:0] blt_x, blt_y;
  logic [11:0]  blt_act;
  logic         shot, invul;

  always #5 clk22 = ~clk22;

  enm_bullet_pool dut (
    .clk22     (clk22),
    .rst       (rst),
    .en        (en),
    .reimux    (reimux),
    .reimuy    (reimuy),
    .enm_x     (enm_x),
    .enm_y     (enm_y),
    .enm_alive (enm_alive),
    .blt_x     (blt_x),
    .blt_y     (blt_y),
    .blt_act   (blt_act),
    .shot      (shot),
    .invul     (invul)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [9:0] bx(input int s);
    return blt_x[s*10 +: 10];
  endfunction

  function automatic logic [9:0] by(input int s);
    return blt_y[s*10 +: 10];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk22);
      #1;
    end
  endtask

  task automatic set_enm(input int e, input logic [9:0] x, input logic [9:0] y);
    enm_x[e*10 +: 10] = x;
    enm_y[e*10 +: 10] = y;
  endtask

  task automatic set_player(input logic [9:0] x, input logic [9:0] y);
    reimux = x;
    reimuy = y;
  endtask

  // One reset edge; afterwards fire counters sit at FIRE_PERIOD-1 = 15.
  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; en = 1'b1;
    enm_x = '0; enm_y = '0; enm_alive = '0;
    set_player(10'd420, 10'd10);
    step(2);

    // Reset state
    check("rst_act",   32'(blt_act), 32'h0);
    check("rst_xy",    32'((blt_x | blt_y) == '0), 32'd1);
    check("rst_shot",  32'(shot),  32'd0);
    check("rst_invul", 32'(invul), 32'd0);

    // Fire/move: enemy0 at (200,40); slots 0/4/8 launch 16 edges after release
    set_enm(0, 10'd200, 10'd40);
    enm_alive = 4'b0001;
    rst = 1'b0;
    step(15);
    check("fire_early", 32'(blt_act), 32'h0);
    step(1);
    check("fire_act", 32'(blt_act), 32'h111);
    check("fire_x0", 32'(bx(0)), 32'd200);
    check("fire_y0", 32'(by(0)), 32'd40);
    check("fire_x4", 32'(bx(4)), 32'd200);
    check("fire_y8", 32'(by(8)), 32'd40);
    step(1);
    check("move_x0", 32'(bx(0)), 32'd200);
    check("move_y0", 32'(by(0)), 32'd50);
    check("move_x4", 32'(bx(4)), 32'd193);
    check("move_y4", 32'(by(4)), 32'd47);
    check("move_x8", 32'(bx(8)), 32'd207);
    check("move_y8", 32'(by(8)), 32'd47);

    // Bounds: enemy0 at (10,40); the d=1 slot would move to x=3 and retires
    set_enm(0, 10'd10, 10'd40);
    do_reset();
    step(16);
    check("bnd_fly4", 32'(blt_act[4]), 32'd1);
    check("bnd_x4",   32'(bx(4)), 32'd10);
    step(1);
    check("bnd_idle4", 32'(blt_act[4]), 32'd0);
    check("bnd_x4_0",  32'(bx(4)), 32'd0);
    check("bnd_y4_0",  32'(by(4)), 32'd0);
    check("bnd_act0",  32'(blt_act[0]), 32'd1);
    check("bnd_y0",    32'(by(0)), 32'd50);
    check("bnd_x8",    32'(bx(8)), 32'd17);

    // Hit + invulnerability: the player steps onto the d=0 bullet at y=100
    set_enm(0, 10'd200, 10'd40);
    set_player(10'd420, 10'd10);
    do_reset();
    step(16);                      // F
    step(6);                       // F+6
    check("hit_y0_100", 32'(by(0)), 32'd100);
    set_player(10'd200, 10'd100);
    step(1);                       // F+7
    check("hit_idle0",  32'(blt_act[0]), 32'd0);
    check("hit_y0_0",   32'(by(0)), 32'd0);
    check("hit_shot",   32'(shot),  32'd1);
    check("hit_invul",  32'(invul), 32'd1);
    step(1);                       // F+8
    check("hit_shot_1cyc", 32'(shot),  32'd0);
    check("hit_invul_on",  32'(invul), 32'd1);
    step(13);                      // F+21: refired bullet enters the hitbox
    check("hit2_fly",  32'(blt_act[0]), 32'd1);
    check("hit2_y90",  32'(by(0)), 32'd90);
    step(1);                       // F+22
    check("hit2_idle",    32'(blt_act[0]), 32'd0);
    check("hit2_noshot",  32'(shot),  32'd0);
    check("hit2_invul",   32'(invul), 32'd1);
    step(16);                      // F+38: third bullet consumed, window not reloaded
    check("hit3_idle",   32'(blt_act[0]), 32'd0);
    check("hit3_noshot", 32'(shot),  32'd0);
    check("inv_last",    32'(invul), 32'd1);
    step(1);                       // F+39
    check("inv_end",     32'(invul), 32'd0);

    // Simultaneous: two d=0 bullets reach the hitbox on the same cycle
    set_enm(0, 10'd200, 10'd40);
    set_enm(1, 10'd205, 10'd40);
    enm_alive = 4'b0011;
    set_player(10'd200, 10'd100);
    do_reset();
    step(16);
    check("sim_act", 32'(blt_act), 32'h333);
    step(5);
    check("sim_y0",     32'(by(0)), 32'd90);
    check("sim_y1",     32'(by(1)), 32'd90);
    check("sim_pre",    32'(shot),  32'd0);
    step(1);
    check("sim_idle01", 32'(blt_act[1:0]), 32'd0);
    check("sim_shot",   32'(shot),  32'd1);
    step(1);
    check("sim_single", 32'(shot),  32'd0);

    // Death: enemy1 drops with 3 slots flying; timer held while dead
    set_enm(1, 10'd100, 10'd40);
    enm_alive = 4'b0010;
    set_player(10'd420, 10'd10);
    do_reset();
    step(16);
    check("dth_act", 32'(blt_act), 32'h222);
    step(2);
    enm_alive = 4'b0000;
    step(1);
    check("dth_idle", 32'(blt_act), 32'h0);
    check("dth_x1",   32'(bx(1)), 32'd0);
    check("dth_y5",   32'(by(5)), 32'd0);
    check("dth_x9",   32'(bx(9)), 32'd0);
    step(3);
    check("dth_stay", 32'(blt_act), 32'h0);
    enm_alive = 4'b0010;
    step(15);
    check("dth_held", 32'(blt_act), 32'h0);
    step(1);
    check("dth_refire", 32'(blt_act), 32'h222);
    check("dth_x5",     32'(bx(5)), 32'd100);

    // en freeze, then reset mid-flight
    set_enm(0, 10'd200, 10'd40);
    enm_alive = 4'b0001;
    do_reset();
    step(18);
    check("frz_y0_pre", 32'(by(0)), 32'd60);
    en = 1'b0;
    step(5);
    check("frz_y0",   32'(by(0)), 32'd60);
    check("frz_x4",   32'(bx(4)), 32'd186);
    check("frz_act",  32'(blt_act), 32'h111);
    check("frz_shot", 32'(shot), 32'd0);
    en = 1'b1;
    step(1);
    check("thaw_y0", 32'(by(0)), 32'd70);
    check("thaw_x4", 32'(bx(4)), 32'd179);
    rst = 1'b1;
    step(1);
    check("mrst_act",   32'(blt_act), 32'h0);
    check("mrst_xy",    32'((blt_x | blt_y) == '0), 32'd1);
    check("mrst_shot",  32'(shot),  32'd0);
    check("mrst_invul", 32'(invul), 32'd0);
    rst = 1'b0;
    step(15);
    check("mrst_early", 32'(blt_act), 32'h0);
    step(1);
    check("mrst_fire",  32'(blt_act), 32'h111);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
